overlap_ctrl: RTL and testbench
===============================

// Module: overlap_ctrl
// PURPOSE
//  Sequencer for the overlap/add datapath of the MPEG-2 AAC decoder: one frame = HALF_WINDOW samples, 4 per beat.
//  Per beat: fetch previous-window tail beat, then current-window head beat, from window RAM onto the shared bus.
//  Pulses overlap.load twice, waits for the registered sum, drives overlap.action and hands the beat downstream.
//  Owns dataBus arbitration: the window RAM and the overlap block never drive the bus together.
// PARAMETERS
//  WORD_LENGTH  16   PCM sample width (matches overlap.wordLength)
//  BUS_SIZE     64   4*WORD_LENGTH, shared dataBus width
//  HALF_WINDOW  512  samples per overlap frame
//  BEAT_AW      7    beat address width, log2(HALF_WINDOW/4)
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        asynchronous, active-low (0 = reset); overlap instance receives ~reset
//  start       in   1        request one frame; sampled only in IDLE
//  busy        out  1        1 from the cycle after start acceptance until DONE inclusive
//  done        out  1        one-cycle pulse, frame complete
//  mem_rd      out  1        window RAM read strobe (1-cycle RAM latency)
//  mem_sel     out  1        0 = previous-window tail, 1 = current-window head
//  mem_addr    out  BEAT_AW  beat address of the read
//  mem_oe      out  1        RAM bus output enable (cycle after mem_rd)
//  ovl_load    out  1        overlap.load
//  ovl_action  out  1        overlap.action (overlap drives dataBus)
//  out_valid   out  1        summed beat valid on dataBus
//  out_ready   in   1        downstream accepts beat
//  out_addr    out  BEAT_AW  beat index of the summed beat
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, beat=0; all outputs 0; stall_count=0 if present. Async reset aborts any frame; no done.
//  FSM: IDLE -> FA on start=1. FA -> LA -> FB -> LB -> SUM -> DRV, one cycle each except DRV.
//   FA: mem_rd=1, mem_sel=0, mem_addr=beat.  LA: mem_oe=1, ovl_load=1 (fills pcm1).
//   FB: mem_rd=1, mem_sel=1, mem_addr=beat.  LB: mem_oe=1, ovl_load=1 (fills pcm2).
//   SUM: all strobes 0; overlap registers pcm1+pcm2 into its output.
//   DRV: ovl_action=1, out_valid=1, out_addr=beat; hold until out_ready=1.
//   DRV with out_ready=1: if beat==HALF_WINDOW/4-1 -> DONE, else beat+1 -> FA.
//   DONE: done=1, busy=1, beat cleared -> IDLE.
//  All outputs are decoded from registered state; no combinational path from out_ready to outputs.
//  Latency: start to first out_valid = 6 cycles; 6 cycles/beat; no stalls -> 128*6+1 = 769 busy cycles.
//  Invariants: mem_oe & ovl_action == 0 always; ovl_load pulses come in pairs.
//   Exactly two per beat keeps overlap's internal first/second toggle aligned with pcm1 = tail, pcm2 = head.
//  start while busy: ignored, no queuing. start in DONE cycle: ignored; reissue in IDLE.
//  out_ready=1 outside DRV: ignored. out_valid never drops before the handshake.
//  Sum is modulo 2^WORD_LENGTH per lane (overlap adder); the controller does no arithmetic on data.
// CONFIGURATION
//  OVERLAP_CTRL_STALL_CNT_EN defined: adds output stall_count [15:0].
//   Counts DRV cycles with out_ready=0 and saturates at 16'hFFFF.
//   Cleared to 0 on start acceptance; holds value after done.
//  Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> all outputs 0, state IDLE; release; no activity without start.
//  2 Single beat data: tail beat lanes 0x0001,0x0002,0x7FFF,0x8000; head 0x0010,0x0020,0x0001,0x8000.
//    Expect dataBus at first out_valid = lanes 0x0011,0x0022,0x8000,0x0000.
//  3 Full frame, out_ready=1: start pulse -> out_valid in cycle 6, 128 beats with out_addr 0..127.
//    Expect done exactly 769 cycles after start, and mem_oe&ovl_action never 1.
//  4 Backpressure: out_ready=0 for 10 cycles on beat 5 -> out_valid/ovl_action held, out_addr=5 stable.
//    Expect stall_count=10 at done when OVERLAP_CTRL_STALL_CNT_EN is defined.
//  5 Abort: reset=0 during beat 40 LB state -> outputs 0 immediately.
//    New start -> beat 0 fetched first; first sum correct (pcm1/pcm2 parity restored).
//  6 start held 1 for whole frame -> exactly one frame, then second frame starts in the cycle after IDLE is entered.

Source files
------------

// File: rtl/overlap_ctrl_if.sv
// Handshake and strobe bundle between overlap_ctrl and the window RAM / overlap / downstream side.
// OVERLAP_CTRL_STALL_CNT_EN adds the stall_count observation output.
interface overlap_ctrl_if #(
    parameter int BEAT_AW = 7
);
    logic               start;
    logic               busy;
    logic               done;
    logic               mem_rd;
    logic               mem_sel;
    logic [BEAT_AW-1:0] mem_addr;
    logic               mem_oe;
    logic               ovl_load;
    logic               ovl_action;
    logic               out_valid;
    logic               out_ready;
    logic [BEAT_AW-1:0] out_addr;
`ifdef OVERLAP_CTRL_STALL_CNT_EN
    logic [15:0]        stall_count;
`endif

    modport master (
`ifdef OVERLAP_CTRL_STALL_CNT_EN
        output stall_count,
`endif
        input  start, out_ready,
        output busy, done, mem_rd, mem_sel, mem_addr, mem_oe,
        output ovl_load, ovl_action, out_valid, out_addr
    );

    modport slave (
`ifdef OVERLAP_CTRL_STALL_CNT_EN
        input  stall_count,
`endif
        output start, out_ready,
        input  busy, done, mem_rd, mem_sel, mem_addr, mem_oe,
        input  ovl_load, ovl_action, out_valid, out_addr
    );
endinterface

// File: rtl/overlap_ctrl.sv
// Beat sequencer for the AAC overlap/add datapath; owns dataBus arbitration (RAM vs overlap).
// Define OVERLAP_CTRL_STALL_CNT_EN to add the saturating backpressure counter stall_count.
//
// state  | meaning
// IDLE   | waiting for start
// FA     | read previous-window tail beat
// LA     | RAM drives bus, overlap loads pcm1
// FB     | read current-window head beat
// LB     | RAM drives bus, overlap loads pcm2
// SUM    | overlap registers pcm1+pcm2
// DRV    | overlap drives bus, beat offered downstream until out_ready
// DONE   | one-cycle frame-complete pulse
module overlap_ctrl #(
    parameter int HALF_WINDOW = 512,
    parameter int BEAT_AW     = 7
) (
    input  logic           clock,
    input  logic           reset,
    overlap_ctrl_if.master ovl
);
    localparam logic [BEAT_AW-1:0] LAST_BEAT = BEAT_AW'(HALF_WINDOW / 4 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FA, S_LA, S_FB, S_LB, S_SUM, S_DRV, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BEAT_AW-1:0] beat_q, beat_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Outputs depend only on state_q/beat_q; out_ready only steers the next state.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        ovl.busy       = (state_q != S_IDLE);
        ovl.done       = 1'b0;
        ovl.mem_rd     = 1'b0;
        ovl.mem_sel    = 1'b0;
        ovl.mem_addr   = '0;
        ovl.mem_oe     = 1'b0;
        ovl.ovl_load   = 1'b0;
        ovl.ovl_action = 1'b0;
        ovl.out_valid  = 1'b0;
        ovl.out_addr   = '0;
        case (state_q)
            S_IDLE: begin
                if (ovl.start) state_d = S_FA;
            end
            S_FA: begin
                ovl.mem_rd   = 1'b1;
                ovl.mem_addr = beat_q;
                state_d      = S_LA;
            end
            S_LA: begin
                ovl.mem_oe   = 1'b1;
                ovl.ovl_load = 1'b1;
                state_d      = S_FB;
            end
            S_FB: begin
                ovl.mem_rd   = 1'b1;
                ovl.mem_sel  = 1'b1;
                ovl.mem_addr = beat_q;
                state_d      = S_LB;
            end
            S_LB: begin
                ovl.mem_oe   = 1'b1;
                ovl.ovl_load = 1'b1;
                state_d      = S_SUM;
            end
            S_SUM: begin
                state_d = S_DRV;
            end
            S_DRV: begin
                ovl.ovl_action = 1'b1;
                ovl.out_valid  = 1'b1;
                ovl.out_addr   = beat_q;
                if (ovl.out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_FA;
                    end
                end
            end
            S_DONE: begin
                ovl.done = 1'b1;
                beat_d   = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

`ifdef OVERLAP_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && ovl.start) begin
            stall_q <= '0;
        end else if (state_q == S_DRV && !ovl.out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign ovl.stall_count = stall_q;
`endif
endmodule

// File: tb/tb_overlap_ctrl.sv
// Bench for overlap_ctrl: emulates window RAM and overlap adder on dataBus, compares
// every cycle against a beat/position model, plus literal checks of the key scenarios.
`timescale 1ns/1ps
module tb_overlap_ctrl;
    localparam int BEAT_AW = 7;
    localparam int BEATS   = 128;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    overlap_ctrl_if #(.BEAT_AW(BEAT_AW)) bus_if();
    overlap_ctrl #(.HALF_WINDOW(512), .BEAT_AW(BEAT_AW)) dut (
        .clock(clock),
        .reset(reset),
        .ovl  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] lane_sum(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        return r;
    endfunction

    // Environment: window RAM (1-cycle latency) and overlap adder sharing dataBus
    logic [63:0] prev_ram [BEATS];
    logic [63:0] head_ram [BEATS];
    logic [63:0] ram_q, pcm1, pcm2, sum_q, data_bus;
    logic        tog;

    assign data_bus = bus_if.mem_oe ? ram_q : (bus_if.ovl_action ? sum_q : 64'h0);

    always @(posedge clock)
        if (bus_if.mem_rd)
            ram_q <= bus_if.mem_sel ? head_ram[bus_if.mem_addr] : prev_ram[bus_if.mem_addr];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            tog <= 1'b0; pcm1 <= '0; pcm2 <= '0; sum_q <= '0;
        end else begin
            if (bus_if.ovl_load) begin
                if (!tog) pcm1 <= data_bus; else pcm2 <= data_bus;
                tog <= ~tog;
            end
            sum_q <= lane_sum(pcm1, pcm2);
        end
    end

    // Reference model: frame active flag, beat index and position 1..6 within the beat
    logic m_active, m_done;
    int   m_pos, m_beat, m_stall;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0; m_done <= 1'b0; m_pos <= 0; m_beat <= 0; m_stall <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (bus_if.start) begin
                m_active <= 1'b1; m_pos <= 1; m_beat <= 0; m_stall <= 0;
            end
        end else if (m_pos < 6) begin
            m_pos <= m_pos + 1;
        end else if (bus_if.out_ready) begin
            if (m_beat == BEATS - 1) begin
                m_active <= 1'b0; m_done <= 1'b1;
            end else begin
                m_beat <= m_beat + 1; m_pos <= 1;
            end
        end else if (m_stall < 65535) begin
            m_stall <= m_stall + 1;
        end
    end

    logic [21:0] all_out;
    assign all_out = {bus_if.busy, bus_if.done, bus_if.mem_rd, bus_if.mem_sel, bus_if.mem_addr,
                      bus_if.mem_oe, bus_if.ovl_load, bus_if.ovl_action, bus_if.out_valid,
                      bus_if.out_addr};

    logic        cmp_en = 1'b0;
    logic [21:0] c_act, c_exp;
    logic        e_rd, e_val;

    always @(negedge clock) begin
        if (cmp_en) begin
            e_rd  = m_active && (m_pos == 1 || m_pos == 3);
            e_val = m_active && (m_pos == 6);
            c_exp = {m_active || m_done, m_done, e_rd, m_active && m_pos == 3,
                     e_rd ? 7'(m_beat) : 7'd0,
                     m_active && (m_pos == 2 || m_pos == 4),
                     m_active && (m_pos == 2 || m_pos == 4),
                     e_val, e_val, e_val ? 7'(m_beat) : 7'd0};
            c_act = {bus_if.busy, bus_if.done, bus_if.mem_rd, bus_if.mem_rd & bus_if.mem_sel,
                     bus_if.mem_rd ? bus_if.mem_addr : 7'd0,
                     bus_if.mem_oe, bus_if.ovl_load, bus_if.ovl_action, bus_if.out_valid,
                     bus_if.out_valid ? bus_if.out_addr : 7'd0};
            check("cycle_outputs", 64'(c_act), 64'(c_exp));
            check("bus_conflict", 64'(bus_if.mem_oe & bus_if.ovl_action), 64'd0);
            if (e_val) check("beat_sum", data_bus, lane_sum(prev_ram[m_beat], head_ram[m_beat]));
`ifdef OVERLAP_CTRL_STALL_CNT_EN
            check("stall_count", 64'(bus_if.stall_count), 64'(m_stall));
`endif
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = ten-cycle hold on beat 5
    int rdy_mode = 0;
    int bp_cnt   = 0;
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: bus_if.out_ready = 1'b1;
            1: bus_if.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (bus_if.out_valid && bus_if.out_addr == 7'd5 && bp_cnt < 10) begin
                    bus_if.out_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    bus_if.out_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic pulse_start(output int t0);
        @(posedge clock); #1;
        bus_if.start = 1'b1;
        t0 = cyc;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic run_frame(output int first_valid, output int done_at, output int hs,
                             output logic [63:0] first_data);
        bit addr_ok = 1'b1;
        bit finished = 1'b0;
        first_valid = -1; done_at = -1; hs = 0; first_data = '0;
        for (int n = 0; n < 6000 && !finished; n++) begin
            @(negedge clock);
            if (bus_if.out_valid && first_valid < 0) begin
                first_valid = cyc;
                first_data  = data_bus;
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (bus_if.out_addr != 7'(hs)) addr_ok = 1'b0;
                hs++;
            end
            if (bus_if.done) begin
                done_at  = cyc;
                finished = 1'b1;
            end
        end
        check("frame_completes", 64'(finished), 64'd1);
        check("out_addr_sequence", 64'(addr_ok), 64'd1);
    endtask

    int          t0, fv, dn, hs;
    logic [63:0] fd;
    bit          activity;
    bit          seen;

    initial begin
        bus_if.start     = 1'b0;
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            prev_ram[i] = {$urandom, $urandom};
            head_ram[i] = {$urandom, $urandom};
        end
        prev_ram[0] = 64'h8000_7FFF_0002_0001;
        head_ram[0] = 64'h8000_0001_0020_0010;

        // Reset held three cycles, then idle without start
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'(all_out), 64'd0);
        reset = 1'b1;
        activity = 1'b0;
        repeat (5) begin
            @(negedge clock);
            activity |= bus_if.busy | bus_if.mem_rd | bus_if.out_valid | bus_if.ovl_load;
        end
        check("idle_no_activity", 64'(activity), 64'd0);

        // Full frame, always ready; first beat data pinned by hand
        rdy_mode = 0;
        pulse_start(t0);
        run_frame(fv, dn, hs, fd);
        check("first_valid_latency", 64'(fv - t0), 64'd6);
        check("first_beat_data", fd, 64'h0000_8000_0022_0011);
        check("done_latency", 64'(dn - t0), 64'd769);
        check("handshakes", 64'(hs), 64'd128);

        // Ten stall cycles on beat 5
        rdy_mode = 2;
        bp_cnt   = 0;
        pulse_start(t0);
        run_frame(fv, dn, hs, fd);
        check("bp_done_latency", 64'(dn - t0), 64'd779);
        check("bp_handshakes", 64'(hs), 64'd128);
`ifdef OVERLAP_CTRL_STALL_CNT_EN
        check("bp_stall_count", 64'(bus_if.stall_count), 64'd10);
`endif

        // Abort in LB of beat 40, then restart from beat 0
        rdy_mode = 1;
        pulse_start(t0);
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clock);
            seen = bus_if.mem_rd && bus_if.mem_sel && bus_if.mem_addr == 7'd40;
        end
        check("reach_beat40_fb", 64'(seen), 64'd1);
        @(posedge clock); #1;
        check("abort_in_lb", 64'(bus_if.ovl_load & bus_if.mem_oe), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_outputs", 64'(all_out), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        rdy_mode = 0;
        pulse_start(t0);
        run_frame(fv, dn, hs, fd);
        check("restart_latency", 64'(fv - t0), 64'd6);
        check("restart_first_data", fd, 64'h0000_8000_0022_0011);

        // start held through a frame: next frame begins right after IDLE
        rdy_mode = 1;
        @(posedge clock); #1;
        bus_if.start = 1'b1;
        run_frame(fv, dn, hs, fd);
        check("held_handshakes", 64'(hs), 64'd128);
        @(negedge clock);
        check("held_idle_busy", 64'(bus_if.busy), 64'd0);
        @(negedge clock);
        check("held_restart", 64'({bus_if.busy, bus_if.mem_rd, bus_if.mem_sel, bus_if.mem_addr}),
              64'({1'b1, 1'b1, 1'b0, 7'd0}));
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        run_frame(fv, dn, hs, fd);
        check("second_handshakes", 64'(hs), 64'd128);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
